// File: rtl/seg_scan_pkg.sv
// Shared types and constants for the 7-segment scan controller.
package seg_scan_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHOW  = 2'd1,
      ST_BLANK = 2'd2
   } state_t;

   localparam logic [6:0] SEG_OFF = 7'h7F;

   // Active-low segments, bit 0 = a ... bit 6 = g, indexed by hex value.
   localparam logic [6:0] HEX_SEG [16] = '{
      7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
   };

endpackage

// File: rtl/seg7_hex_dec.sv
// Combinational hex nibble to active-low 7-segment decoder.
module seg7_hex_dec
   import seg_scan_pkg::*;
(
   input  logic [3:0] iHex,
   output logic [6:0] oSeg
);

   assign oSeg = HEX_SEG[iHex];

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed common-anode 7-segment scan controller with frame-aligned shadow loading.
// Optional leading-zero blanking is built when SEG_SCAN_LZB_EN is defined.
module seg_scan_ctrl
   import seg_scan_pkg::*;
#(
   parameter int NUM_DIGITS   = 4,
   parameter int PRESCALE     = 50000,
   parameter int BLANK_CYCLES = 16
) (
   input  logic                    CLK,
   input  logic                    rst,
   input  logic                    iEnable,
   input  logic                    iValid,
   output logic                    oReady,
   input  logic [4*NUM_DIGITS-1:0] iDigits,
   input  logic [NUM_DIGITS-1:0]   iMask,
   output logic [NUM_DIGITS-1:0]   oAn,
   output logic [6:0]              oSeg,
   output logic                    oFrame
);

   localparam int CNT_MAX = (PRESCALE > BLANK_CYCLES) ? PRESCALE : BLANK_CYCLES;
   localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
   localparam int IW      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam logic [CW-1:0] SHOW_LAST  = CW'(PRESCALE - 1);
   localparam logic [CW-1:0] BLANK_LAST = CW'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);

   state_t                  state_q, state_d;
   logic [IW-1:0]           idx_q, idx_d, idx_nxt;
   logic [CW-1:0]           cnt_q, cnt_d;
   logic                    frame_q, frame_d;
   logic                    shadow_full_q, shadow_full_d;
   logic [4*NUM_DIGITS-1:0] shadow_dig_q, shadow_dig_d;
   logic [NUM_DIGITS-1:0]   shadow_mask_q, shadow_mask_d;
   logic [4*NUM_DIGITS-1:0] act_dig_q, act_dig_d;
   logic [NUM_DIGITS-1:0]   act_mask_q, act_mask_d;

   logic                    boundary;
   logic [3:0]              nib;
   logic                    sel_mask, sel_dark, lit;
   logic [NUM_DIGITS-1:0]   dark;
   logic [6:0]              dec_seg;

   always_ff @(posedge CLK or posedge rst) begin
      if (rst) begin
         state_q       <= ST_IDLE;
         idx_q         <= '0;
         cnt_q         <= '0;
         frame_q       <= 1'b0;
         shadow_full_q <= 1'b0;
         shadow_dig_q  <= '0;
         shadow_mask_q <= '0;
         act_dig_q     <= '0;
         act_mask_q    <= '0;
      end else begin
         state_q       <= state_d;
         idx_q         <= idx_d;
         cnt_q         <= cnt_d;
         frame_q       <= frame_d;
         shadow_full_q <= shadow_full_d;
         shadow_dig_q  <= shadow_dig_d;
         shadow_mask_q <= shadow_mask_d;
         act_dig_q     <= act_dig_d;
         act_mask_q    <= act_mask_d;
      end
   end

   assign idx_nxt = (idx_q == IW'(NUM_DIGITS - 1)) ? '0 : idx_q + IW'(1);

   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      cnt_d    = cnt_q;
      boundary = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (iEnable) begin
               state_d  = ST_SHOW;
               idx_d    = '0;
               cnt_d    = '0;
               boundary = 1'b1;
            end
         end
         ST_SHOW: begin
            if (!iEnable) begin
               state_d = ST_IDLE;
               idx_d   = '0;
               cnt_d   = '0;
            end else if (cnt_q == SHOW_LAST) begin
               cnt_d = '0;
               if (BLANK_CYCLES == 0) begin
                  idx_d    = idx_nxt;
                  boundary = (idx_nxt == '0);
               end else begin
                  state_d = ST_BLANK;
               end
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         ST_BLANK: begin
            if (!iEnable) begin
               state_d = ST_IDLE;
               idx_d   = '0;
               cnt_d   = '0;
            end else if (cnt_q == BLANK_LAST) begin
               state_d  = ST_SHOW;
               cnt_d    = '0;
               idx_d    = idx_nxt;
               boundary = (idx_nxt == '0);
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         default: begin
            state_d = ST_IDLE;
            idx_d   = '0;
            cnt_d   = '0;
         end
      endcase
   end

   // The shadow is promoted before a capture is considered; a full shadow blocks capture on that edge.
   always_comb begin
      frame_d       = boundary;
      shadow_full_d = shadow_full_q;
      shadow_dig_d  = shadow_dig_q;
      shadow_mask_d = shadow_mask_q;
      act_dig_d     = act_dig_q;
      act_mask_d    = act_mask_q;
      if (boundary && shadow_full_q) begin
         act_dig_d     = shadow_dig_q;
         act_mask_d    = shadow_mask_q;
         shadow_full_d = 1'b0;
      end
      if (iValid && !shadow_full_q) begin
         shadow_dig_d  = iDigits;
         shadow_mask_d = iMask;
         shadow_full_d = 1'b1;
      end
   end

`ifdef SEG_SCAN_LZB_EN
   logic upper_zero;
   always_comb begin
      upper_zero = 1'b1;
      dark       = '0;
      for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
         upper_zero = upper_zero & (act_dig_q[4*k +: 4] == 4'h0);
         if (k > 0) dark[k] = upper_zero;
      end
   end
`else
   assign dark = '0;
`endif

   always_comb begin
      nib      = 4'h0;
      sel_mask = 1'b0;
      sel_dark = 1'b0;
      for (int k = 0; k < NUM_DIGITS; k++) begin
         if (idx_q == IW'(k)) begin
            nib      = act_dig_q[4*k +: 4];
            sel_mask = act_mask_q[k];
            sel_dark = dark[k];
         end
      end
   end

   seg7_hex_dec u_dec (
      .iHex (nib),
      .oSeg (dec_seg)
   );

   assign lit = (state_q == ST_SHOW) && sel_mask && !sel_dark;

   always_comb begin
      oAn = '1;
      for (int k = 0; k < NUM_DIGITS; k++) begin
         if (lit && (idx_q == IW'(k))) oAn[k] = 1'b0;
      end
      oSeg = lit ? dec_seg : SEG_OFF;
   end

   assign oReady = ~shadow_full_q;
   assign oFrame = frame_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl: frame-position reference model, directed steps then random traffic.
// Define SEG_SCAN_LZB_EN for both bench and RTL to cover leading-zero blanking.
module tb_seg_scan_ctrl;

   localparam int ND    = 4;
   localparam int PS    = 4;
   localparam int BC    = 2;
   localparam int SLOT  = PS + BC;
   localparam int FRAME = ND * SLOT;

   logic        CLK = 1'b0;
   logic        rst;
   logic        iEnable;
   logic        iValid;
   logic        oReady;
   logic [15:0] iDigits;
   logic [3:0]  iMask;
   logic [3:0]  oAn;
   logic [6:0]  oSeg;
   logic        oFrame;

   always #5 CLK = ~CLK;

   seg_scan_ctrl #(
      .NUM_DIGITS   (ND),
      .PRESCALE     (PS),
      .BLANK_CYCLES (BC)
   ) dut (
      .CLK     (CLK),
      .rst     (rst),
      .iEnable (iEnable),
      .iValid  (iValid),
      .oReady  (oReady),
      .iDigits (iDigits),
      .iMask   (iMask),
      .oAn     (oAn),
      .oSeg    (oSeg),
      .oFrame  (oFrame)
   );

   int total = 0;
   int bad   = 0;

   // Reference: scanning flag, position within the frame, shadow and active contents.
   bit          m_run;
   int          m_t;
   bit          m_sh_full;
   logic [15:0] m_sh_dig, m_act_dig;
   logic [3:0]  m_sh_mask, m_act_mask;

   logic [6:0] ref_seg [16] = '{
      7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
   };

   task automatic model_reset();
      m_run      = 1'b0;
      m_t        = 0;
      m_sh_full  = 1'b0;
      m_sh_dig   = '0;
      m_sh_mask  = '0;
      m_act_dig  = '0;
      m_act_mask = '0;
   endtask

   task automatic model_update(input bit en, input bit v, input logic [15:0] d, input logic [3:0] m);
      bit bnd;
      bit cap;
      bnd = en && (!m_run || m_t == FRAME - 1);
      cap = v && !m_sh_full;
      if (!en) begin
         m_run = 1'b0;
         m_t   = 0;
      end else if (!m_run) begin
         m_run = 1'b1;
         m_t   = 0;
      end else begin
         m_t = (m_t + 1) % FRAME;
      end
      if (bnd && m_sh_full) begin
         m_act_dig  = m_sh_dig;
         m_act_mask = m_sh_mask;
         m_sh_full  = 1'b0;
      end
      if (cap) begin
         m_sh_dig  = d;
         m_sh_mask = m;
         m_sh_full = 1'b1;
      end
   endtask

   task automatic check(input string tag);
      int         slot;
      int         w;
      int         msd;
      bit         lit;
      logic [3:0] nib;
      logic [3:0] onehot;
      logic [3:0] exp_an;
      logic [6:0] exp_seg;
      logic       exp_frame;
      logic       exp_ready;
      slot = m_t / SLOT;
      w    = m_t % SLOT;
      nib  = 4'(m_act_dig >> (4 * slot));
      lit  = m_run && (w < PS) && m_act_mask[slot];
`ifdef SEG_SCAN_LZB_EN
      msd = 0;
      for (int k = 0; k < ND; k++) if (4'(m_act_dig >> (4 * k)) != 4'h0) msd = k;
      if (slot > msd) lit = 1'b0;
`else
      msd = 0;
`endif
      onehot    = 4'b0001 << slot;
      exp_an    = lit ? ~onehot : 4'hF;
      exp_seg   = lit ? ref_seg[nib] : 7'h7F;
      exp_frame = m_run && (m_t == 0);
      exp_ready = !m_sh_full;
      total++;
      assert (oAn === exp_an) else begin
         bad++;
         $error("FAIL %s oAn t=%0d obs=%h exp=%h", tag, m_t, oAn, exp_an);
      end
      total++;
      assert (oSeg === exp_seg) else begin
         bad++;
         $error("FAIL %s oSeg t=%0d obs=%h exp=%h", tag, m_t, oSeg, exp_seg);
      end
      total++;
      assert (oFrame === exp_frame) else begin
         bad++;
         $error("FAIL %s oFrame t=%0d obs=%b exp=%b", tag, m_t, oFrame, exp_frame);
      end
      total++;
      assert (oReady === exp_ready) else begin
         bad++;
         $error("FAIL %s oReady t=%0d obs=%b exp=%b", tag, m_t, oReady, exp_ready);
      end
   endtask

   // Inputs are stable from the previous negedge; sample them, clock, update model, check at negedge.
   task automatic step(input string tag);
      bit          en, v;
      logic [15:0] d;
      logic [3:0]  m;
      en = iEnable;
      v  = iValid;
      d  = iDigits;
      m  = iMask;
      @(posedge CLK);
      model_update(en, v, d, m);
      @(negedge CLK);
      check(tag);
   endtask

   task automatic run_until(input int t, input string tag);
      int n;
      n = 0;
      while (!(m_run && m_t == t) && n < 2 * FRAME) begin
         step(tag);
         n++;
      end
   endtask

   initial begin
      logic [31:0] r;
      rst     = 1'b1;
      iEnable = 1'b0;
      iValid  = 1'b0;
      iDigits = '0;
      iMask   = '0;
      model_reset();
      repeat (2) @(negedge CLK);
      check("reset");
      rst = 1'b0;
      repeat (4) step("idle");

      // Load into the shadow while idle, then start scanning.
      iDigits = 16'h3210;
      iMask   = 4'hF;
      iValid  = 1'b1;
      step("load");
      iValid = 1'b0;
      step("load_hold");
      iEnable = 1'b1;
      repeat (2 * FRAME) step("scan");

      // Mid-frame capture, then a held-off second value that must be ignored.
      run_until(9, "to_mid");
      iDigits = 16'hAAAA;
      iValid  = 1'b1;
      step("cap_aaaa");
      iDigits = 16'h5555;
      step("cap_ignored");
      iValid = 1'b0;
      run_until(0, "to_frame");
      repeat (FRAME) step("show_aaaa");

      // Masked slots keep their timing.
      iDigits = 16'h3210;
      iMask   = 4'b0101;
      iValid  = 1'b1;
      step("cap_mask");
      iValid = 1'b0;
      repeat (2 * FRAME + 4) step("masked");

      // Drop enable during BLANK after digit 2, then resume from digit 0.
      run_until(2 * SLOT + PS, "to_blank2");
      iEnable = 1'b0;
      step("drop_en");
      repeat (3) step("dropped");
      iEnable = 1'b1;
      repeat (FRAME + 3) step("resume");

      // Asynchronous reset in the middle of a SHOW cycle.
      run_until(2, "to_show0");
      #2 rst = 1'b1;
      #1 model_reset();
      check("async_rst");
      iEnable = 1'b0;
      @(negedge CLK);
      check("rst_held");
      rst = 1'b0;
      repeat (4) step("post_rst");

      // Upper zero nibbles (dark under leading-zero blanking).
      iDigits = 16'h0050;
      iMask   = 4'hF;
      iValid  = 1'b1;
      step("cap_0050");
      iValid  = 1'b0;
      iEnable = 1'b1;
      repeat (2 * FRAME) step("lzb");

      // Random traffic.
      for (int i = 0; i < 500; i++) begin
         r       = $urandom;
         iValid  = ($urandom_range(0, 5) == 0);
         iDigits = 16'(r >> (4 * $urandom_range(0, 4)));
         iMask   = 4'($urandom_range(0, 15));
         if (iEnable && $urandom_range(0, 59) == 0) iEnable = 1'b0;
         else if (!iEnable && $urandom_range(0, 3) == 0) iEnable = 1'b1;
         step("rand");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
- Time-multiplexed scan controller for a bank of common-anode 7-segment digits.
- Shares one hex-to-segment decoder between NUM_DIGITS digit sources.
- Sequences the anode strobes with a prescaled dwell and a blanking gap that prevents ghosting.
- Accepts new digit values through a valid/ready shadow register; values take effect only at frame boundaries, so the display never tears.

Parameters:
- NUM_DIGITS, 4, number of multiplexed digits (legal range 1..8).
- PRESCALE, 50000, CLK cycles each digit is lit (minimum 1).
- BLANK_CYCLES, 16, CLK cycles all anodes are off between digits (0 removes the BLANK state).

Ports:
- CLK  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- iEnable  in  1  scanning on when 1; when 0, all anodes off.
- iValid  in  1  iDigits is valid this cycle.
- oReady  out  1  shadow register empty; a capture is accepted this cycle.
- iDigits  in  4*NUM_DIGITS  nibble k is the hex value for digit k.
- iMask  in  NUM_DIGITS  1 = digit k is enabled; 0 = its slot runs but its anode stays off.
- oAn  out  NUM_DIGITS  anode strobes, active-low.
- oSeg  out  7  segments a..g on bits 0..6, active-low.
- oFrame  out  1  one-cycle pulse when digit 0 begins a new frame.

Behaviour:
- Reset values:
  - state IDLE, digit index 0, prescaler 0.
  - active digits and active mask all 0; shadow empty.
  - oAn all 1, oSeg 7'h7F, oReady 1, oFrame 0.
- Reset mid-scan: immediately forces the reset values, regardless of state.
- Outputs: Moore, decoded from registered state and active registers only. No combinational path from any input to oAn or oSeg.
- FSM states: IDLE, SHOW, BLANK.
- IDLE:
  - oAn all 1, oSeg 7'h7F.
  - iEnable=1 → SHOW with index 0 at the next edge; this counts as a frame boundary.
- SHOW:
  - oAn[index]=0 if active mask[index]=1, else all 1.
  - oSeg = decode(active nibble[index]) if the anode is lit, else 7'h7F.
  - Stays for exactly PRESCALE cycles, then → BLANK, or → next SHOW if BLANK_CYCLES=0.
- BLANK:
  - oAn all 1, oSeg 7'h7F.
  - Stays BLANK_CYCLES cycles, then → SHOW with index+1.
- Index wrap:
  - Index wraps from NUM_DIGITS-1 to 0; entering SHOW with index 0 is a frame boundary.
  - With NUM_DIGITS=1, every entry to SHOW is a boundary.
  - Frame period is NUM_DIGITS*(PRESCALE+BLANK_CYCLES).
- Frame boundary, on the same edge as the transition:
  - oFrame=1 for exactly the first SHOW cycle.
  - If the shadow is full, shadow digits and mask are copied to active and the shadow is cleared.
- Handshake:
  - oReady = ~shadow_full.
  - iValid & oReady captures iDigits and iMask into the shadow.
  - iValid with oReady=0 is ignored; the source must hold the data.
- Capture on a boundary edge, shadow empty: the new data goes into the shadow, not straight to active, and applies at the next boundary.
- Capture on a boundary edge, shadow full: no capture. The shadow empties on that edge and oReady rises the following cycle.
- iEnable low in SHOW or BLANK: → IDLE at the next edge; index and prescaler clear to 0; shadow and active registers are retained.
- Decoder: standard hex 0..F, active-low.
  - 0 → 7'h40, 1 → 7'h79, 8 → 7'h00, A → 7'h08, F → 7'h0E.

Optional Feature:
- Macro: SEG_SCAN_LZB_EN (leading-zero blanking).
- Defined:
  - Any digit k > 0 is forced dark (anode off, oSeg 7'h7F) when active nibbles k..NUM_DIGITS-1 are all zero.
  - Digit 0 is never forced dark.
  - Slot timing is unchanged.
- Undefined: zeros display normally; no extra logic is built.

Decomposition:
- Package seg_scan_pkg holds:
  - state encoding typedef (IDLE/SHOW/BLANK);
  - SEG_OFF = 7'h7F;
  - the 16-entry hex segment constant table.
- One sub-module, seg7_hex_dec: combinational, 4-bit in, 7-bit active-low out, built from the package table. It is instantiated once inside seg_scan_ctrl.

Test Plan (NUM_DIGITS=4, PRESCALE=4, BLANK_CYCLES=2):
- Reset asserted mid-SHOW → oAn=4'hF, oSeg=7'h7F, oReady=1 asynchronously; after release with iEnable=0, outputs stay idle.
- Load iDigits=16'h3210, iMask=4'hF, then iEnable=1 → oFrame pulse; each anode low for 4 cycles in order 0,1,2,3, separated by 2 dark cycles; oSeg = 7'h40, 7'h79, 7'h24, 7'h30; period 24 cycles.
- Capture 16'hAAAA mid-frame → oReady=0 the next cycle; display unchanged until the next oFrame; oSeg=7'h08 from digit 0 onward; oReady=1 after the boundary.
- iMask=4'b0101 → oAn[1] and oAn[3] never low; slots 1 and 3 still take 4 cycles, so the period stays 24.
- Drop iEnable during BLANK of digit 2 → IDLE at the next edge; re-enable → digit 0 with oFrame, active values retained.
- With SEG_SCAN_LZB_EN, iDigits=16'h0050 → digits 0 and 1 lit (7'h40, 7'h12); digits 2 and 3 dark.
